// File: rtl/rsv_station_pkg.sv
// Shared core types: tag/opcode widths, null tag and reservation entry layout.
// Also used by the register file unit.
package rsv_station_pkg;

   localparam int TAG_W_DFLT = 4;
   localparam int OPC_W_DFLT = 8;
   localparam int DATA_W     = 32;
   localparam int AGE_W      = 4;

   localparam logic [TAG_W_DFLT-1:0] NULL_TAG = '0;

   typedef struct packed {
      logic                  rdy;
      logic [TAG_W_DFLT-1:0] tag;
      logic [DATA_W-1:0]     data;
   } rs_opnd_t;

   typedef struct packed {
      logic                  vld;
      logic [OPC_W_DFLT-1:0] opc;
      logic [TAG_W_DFLT-1:0] dst_tag;
      rs_opnd_t              rs1;
      rs_opnd_t              rs2;
   } rs_entry_t;

endpackage

// File: rtl/rsv_station_select.sv
// rsv_select: eligible vector in, one-hot grant out.
// RSV_STATION_AGE_EN picks the oldest eligible entry, else the lowest index.
module rsv_select
   import rsv_station_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0]            elig,
`ifdef RSV_STATION_AGE_EN
   input  logic [DEPTH-1:0][AGE_W-1:0] age,
`endif
   output logic [DEPTH-1:0]            gnt
);

`ifdef RSV_STATION_AGE_EN
   // Ranks are unique among valid entries; the index tiebreak keeps it one-hot.
   always_comb begin
      gnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         gnt[i] = elig[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && elig[j] &&
                (age[j] < age[i] || (age[j] == age[i] && j < i)))
               gnt[i] = 1'b0;
         end
      end
   end
`else
   always_comb begin
      gnt = elig & (~elig + DEPTH'(1));
   end
`endif

endmodule

// File: rtl/rsv_station.sv
// Reservation station: CDB wakeup, one issue per cycle to the functional unit.
// Define RSV_STATION_AGE_EN for oldest-first selection.
module rsv_station
   import rsv_station_pkg::*;
#(
   parameter int TAG_W = TAG_W_DFLT,
   parameter int DEPTH = 4,
   parameter int OPC_W = OPC_W_DFLT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              dsp_vld,
   output logic              dsp_rdy,
   input  logic [OPC_W-1:0]  dsp_opc,
   input  logic [TAG_W-1:0]  dsp_dst_tag,
   input  logic              dsp_rs1_busy,
   input  logic [TAG_W-1:0]  dsp_rs1_tag,
   input  logic [31:0]       dsp_rs1_data,
   input  logic              dsp_rs2_busy,
   input  logic [TAG_W-1:0]  dsp_rs2_tag,
   input  logic [31:0]       dsp_rs2_data,
   input  logic              cdb_wr,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [31:0]       cdb_wdata,
   output logic              iss_vld,
   input  logic              iss_rdy,
   output logic [OPC_W-1:0]  iss_opc,
   output logic [TAG_W-1:0]  iss_dst_tag,
   output logic [31:0]       iss_rs1_data,
   output logic [31:0]       iss_rs2_data
);

   rs_entry_t                 ent_q [DEPTH];
   rs_entry_t                 new_ent;
   rs_entry_t                 sel;
   logic [DEPTH-1:0]          vld;
   logic [DEPTH-1:0]          elig;
   logic [DEPTH-1:0]          free_oh;
   logic [DEPTH-1:0]          gnt;
   logic [TAG_W_DFLT-1:0]     cdb_tag_c;
   logic                      dsp_fire;
   logic                      iss_fire;

   assign cdb_tag_c = TAG_W_DFLT'(cdb_tag);

   always_comb begin
      vld  = '0;
      elig = '0;
      for (int i = 0; i < DEPTH; i++) begin
         vld[i]  = ent_q[i].vld;
         elig[i] = ent_q[i].vld & ent_q[i].rs1.rdy & ent_q[i].rs2.rdy;
      end
   end

   // Lowest clear bit of the registered valid vector.
   assign free_oh  = ~vld & (vld + DEPTH'(1));
   assign dsp_rdy  = ~&vld;
   assign dsp_fire = dsp_vld & dsp_rdy & ~flush;
   assign iss_vld  = |gnt;
   assign iss_fire = iss_vld & iss_rdy & ~flush;

`ifdef RSV_STATION_AGE_EN
   logic [DEPTH-1:0][AGE_W-1:0] age_q;
   logic [AGE_W-1:0]            n_vld;
   logic [AGE_W-1:0]            gnt_age;
   logic [AGE_W-1:0]            new_age;

   always_comb begin
      n_vld   = '0;
      gnt_age = '0;
      for (int i = 0; i < DEPTH; i++) begin
         n_vld = n_vld + AGE_W'(ent_q[i].vld);
         if (gnt[i])
            gnt_age = age_q[i];
      end
      new_age = n_vld - AGE_W'(iss_fire);
   end

   // Rank = number of live entries dispatched earlier.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         age_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (iss_fire && ent_q[i].vld && age_q[i] > gnt_age)
               age_q[i] <= age_q[i] - AGE_W'(1);
            if (dsp_fire && free_oh[i])
               age_q[i] <= new_age;
         end
      end
   end
`endif

   rsv_select #(
      .DEPTH(DEPTH)
   ) u_sel (
      .elig(elig),
`ifdef RSV_STATION_AGE_EN
      .age (age_q),
`endif
      .gnt (gnt)
   );

   always_comb begin
      new_ent          = '0;
      new_ent.vld      = 1'b1;
      new_ent.opc      = OPC_W_DFLT'(dsp_opc);
      new_ent.dst_tag  = TAG_W_DFLT'(dsp_dst_tag);
      new_ent.rs1.rdy  = ~dsp_rs1_busy;
      new_ent.rs1.tag  = dsp_rs1_busy ? TAG_W_DFLT'(dsp_rs1_tag) : NULL_TAG;
      new_ent.rs1.data = dsp_rs1_data;
      new_ent.rs2.rdy  = ~dsp_rs2_busy;
      new_ent.rs2.tag  = dsp_rs2_busy ? TAG_W_DFLT'(dsp_rs2_tag) : NULL_TAG;
      new_ent.rs2.data = dsp_rs2_data;
   end

   always_comb begin
      sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (gnt[i])
            sel = ent_q[i];
      end
   end

   assign iss_opc      = OPC_W'(sel.opc);
   assign iss_dst_tag  = TAG_W'(sel.dst_tag);
   assign iss_rs1_data = sel.rs1.data;
   assign iss_rs2_data = sel.rs2.data;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            ent_q[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++)
            ent_q[i].vld <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (cdb_wr && ent_q[i].vld && !ent_q[i].rs1.rdy &&
                ent_q[i].rs1.tag == cdb_tag_c) begin
               ent_q[i].rs1.rdy  <= 1'b1;
               ent_q[i].rs1.tag  <= NULL_TAG;
               ent_q[i].rs1.data <= cdb_wdata;
            end
            if (cdb_wr && ent_q[i].vld && !ent_q[i].rs2.rdy &&
                ent_q[i].rs2.tag == cdb_tag_c) begin
               ent_q[i].rs2.rdy  <= 1'b1;
               ent_q[i].rs2.tag  <= NULL_TAG;
               ent_q[i].rs2.data <= cdb_wdata;
            end
            if (iss_fire && gnt[i])
               ent_q[i].vld <= 1'b0;
            if (dsp_fire && free_oh[i])
               ent_q[i] <= new_ent;
         end
      end
   end

endmodule
